// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int DFLT_BAUD_DIV = 2604;
  localparam int DATA_BITS     = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line, plus falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic RX,
  output logic rx_s,
  output logic fall
);

  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;

  // Flops reset to the idle-high level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_s = rx_s_q;
  assign fall = rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: start-bit glitch rejection, framing-error pulse,
// and a rdy/clr_rdy handshake on the received byte.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DFLT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL     = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF     = CW'(BAUD_DIV / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .RX   (RX),
    .rx_s (rx_s),
    .fall (fall)
  );

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [7:0]           data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 frm_q, frm_d;
  logic                 shift_en;
  logic                 tick;

  // Expiry is the cycle the down-counter steps to zero, so a load of N
  // spaces samples exactly N clocks apart.
  assign tick = (baud_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      frm_q   <= frm_d;
    end
  end

  // Right shift so the first (LSB) bit ends up in bit 0 after eight samples.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    frm_d    = 1'b0;
    shift_en = 1'b0;

    if (clr_rdy) begin
      rdy_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          baud_d  = HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d = DATA;
            baud_d  = FULL;
            bit_d   = '0;
            rdy_d   = 1'b0;
          end else begin
            state_d = IDLE;
            baud_d  = '0;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          bit_d    = bit_q + BW'(1);
          baud_d   = FULL;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          baud_d  = '0;
          if (rx_s) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
          end else begin
            frm_d = 1'b1;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  assign rx_data = data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_q;

endmodule
